// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;
  localparam logic [3:0] DIGIT_RELOAD    = 4'd9;
  localparam logic [3:0] ZERO_DIGIT      = 4'd0;

endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD digit that can be loaded or decremented, wrapping to a reload value on borrow.
module bcd_digit_down (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic [3:0] reload_val,
  output logic [3:0] value,
  output logic       is_zero
);

  always_ff @(posedge clock) begin
    if (clear)
      value <= 4'd0;
    else if (load)
      value <= load_val;
    else if (dec)
      value <= (value == 4'd0) ? reload_val : value - 4'd1;
  end

  assign is_zero = (value == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Microwave mm:ss countdown: keypad shift-in entry, tick-driven BCD decrement, run/pause/done FSM.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int MAX_DIGIT = 9
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

  state_t state, next_state;
  logic   load, shift, dec_tick;
  logic   z_mt, z_mo, z_st, z_so;
  logic   dec_so, dec_st, dec_mo, dec_mt;
  logic   time_zero, at_one;

  assign time_zero = z_mt & z_mo & z_st & z_so;
  assign at_one    = z_mt & z_mo & z_st & (sec_ones == 4'd1);

  // Borrow ripples from seconds-ones upward; a digit steps only when all below it wrap.
  assign dec_so = dec_tick;
  assign dec_st = dec_so & z_so;
  assign dec_mo = dec_st & z_st;
  assign dec_mt = dec_mo & z_mo;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    dec_tick   = 1'b0;
    if (cancel) begin
      next_state = IDLE;
      load       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !time_zero && !door_open)
            next_state = RUN;
          else if (digit_valid && (digit <= MAX_D)) begin
            load  = 1'b1;
            shift = 1'b1;
          end
        end
        RUN: begin
          if (pause || door_open)
            next_state = PAUSE;
          else if (tick) begin
            dec_tick = 1'b1;
            if (at_one)
              next_state = DONE;
          end
        end
        PAUSE: begin
          if (start && !door_open)
            next_state = RUN;
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      done    <= (next_state == DONE);
    end
  end

  // Cancel loads zeros; keypad entry loads each digit from its right-hand neighbour.
  bcd_digit_down u_min_tens (
    .clock(clock), .clear(clear), .load(load),
    .load_val(shift ? min_ones : ZERO_DIGIT),
    .dec(dec_mt), .reload_val(DIGIT_RELOAD),
    .value(min_tens), .is_zero(z_mt)
  );

  bcd_digit_down u_min_ones (
    .clock(clock), .clear(clear), .load(load),
    .load_val(shift ? sec_tens : ZERO_DIGIT),
    .dec(dec_mo), .reload_val(DIGIT_RELOAD),
    .value(min_ones), .is_zero(z_mo)
  );

  bcd_digit_down u_sec_tens (
    .clock(clock), .clear(clear), .load(load),
    .load_val(shift ? sec_ones : ZERO_DIGIT),
    .dec(dec_st), .reload_val(SEC_TENS_RELOAD),
    .value(sec_tens), .is_zero(z_st)
  );

  bcd_digit_down u_sec_ones (
    .clock(clock), .clear(clear), .load(load),
    .load_val(shift ? digit : ZERO_DIGIT),
    .dec(dec_so), .reload_val(DIGIT_RELOAD),
    .value(sec_ones), .is_zero(z_so)
  );

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: entry, countdown, pause/door/cancel/clear behaviour.
module tb_bcd_countdown_timer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       tick = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       cancel = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done;

  int checks = 0;
  int failures = 0;

  bcd_countdown_timer #(.MAX_DIGIT(9)) dut (
    .clock(clock), .clear(clear), .tick(tick),
    .digit_valid(digit_valid), .digit(digit),
    .start(start), .pause(pause), .cancel(cancel), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done)
  );

  always #5 clock = ~clock;

  // One clock edge, then release all one-cycle pulse inputs; door_open is a level.
  task automatic cyc();
    @(posedge clock);
    #1;
    clear = 1'b0; tick = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    start = 1'b0; pause = 1'b0; cancel = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1; digit = d; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
    end
  endtask

  task automatic chk_time(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    clear = 1'b1; cyc();
    chk_time("reset_digits", 16'h0000);
    chk_bit("reset_running", running, 1'b0);
    chk_bit("reset_done", done, 1'b0);

    // entry 1,3,0 and full countdown of 90 s
    key(4'd1); key(4'd3); key(4'd0);
    chk_time("entry_0130", 16'h0130);
    start = 1'b1; cyc();
    chk_bit("start_running", running, 1'b1);
    chk_time("start_hold", 16'h0130);
    ticks(30);
    chk_time("after30_0100", 16'h0100);
    ticks(1);
    chk_time("after31_0059", 16'h0059);
    ticks(58);
    chk_time("after89_0001", 16'h0001);
    chk_bit("after89_done", done, 1'b0);
    ticks(1);
    chk_time("after90_0000", 16'h0000);
    chk_bit("after90_done", done, 1'b1);
    chk_bit("after90_running", running, 1'b0);
    cyc();
    chk_bit("done_one_cycle", done, 1'b0);
    chk_bit("idle_running", running, 1'b0);

    // shift overflow and out-of-range digit
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk_time("shift_2345", 16'h2345);
    key(4'd12);
    chk_time("digit12_ignored", 16'h2345);
    cancel = 1'b1; cyc();
    chk_time("cancel_idle", 16'h0000);

    // zero start
    start = 1'b1; cyc();
    chk_bit("zero_start_running", running, 1'b0);
    chk_bit("zero_start_done", done, 1'b0);
    cyc();
    chk_bit("zero_start_done2", done, 1'b0);

    // minute borrow 10:00 -> 09:59
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    start = 1'b1; cyc();
    ticks(1);
    chk_time("borrow_0959", 16'h0959);
    cancel = 1'b1; cyc();

    // tick coinciding with pause is dropped
    key(4'd1); key(4'd0);
    start = 1'b1; cyc();
    tick = 1'b1; pause = 1'b1; cyc();
    chk_time("tickpause_0010", 16'h0010);
    chk_bit("tickpause_running", running, 1'b0);
    start = 1'b1; cyc();
    chk_bit("resume_running", running, 1'b1);
    ticks(1);
    chk_time("resume_0009", 16'h0009);

    // door interlock
    door_open = 1'b1; cyc();
    chk_bit("door_pause", running, 1'b0);
    start = 1'b1; cyc();
    chk_bit("door_start_ignored", running, 1'b0);
    ticks(1);
    chk_time("door_hold_0009", 16'h0009);
    door_open = 1'b0; cyc();
    start = 1'b1; cyc();
    chk_bit("door_closed_run", running, 1'b1);
    ticks(1);
    chk_time("door_resume_0008", 16'h0008);

    // clear mid-run at 05:00
    cancel = 1'b1; cyc();
    key(4'd5); key(4'd0); key(4'd0);
    start = 1'b1; cyc();
    chk_bit("run_0500", running, 1'b1);
    clear = 1'b1; cyc();
    chk_time("clear_digits", 16'h0000);
    chk_bit("clear_running", running, 1'b0);
    chk_bit("clear_done", done, 1'b0);

    // cancel mid-run at 05:00, then a tick in IDLE does nothing
    key(4'd5); key(4'd0); key(4'd0);
    start = 1'b1; cyc();
    cancel = 1'b1; tick = 1'b1; cyc();
    chk_time("cancel_digits", 16'h0000);
    chk_bit("cancel_running", running, 1'b0);
    chk_bit("cancel_done", done, 1'b0);
    ticks(1);
    chk_time("idle_tick_0000", 16'h0000);

    // maximum entry 99:99 counts 6039 ticks
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    start = 1'b1; cyc();
    ticks(100);
    chk_time("max_after100_9859", 16'h9859);
    ticks(5938);
    chk_time("max_after6038_0001", 16'h0001);
    ticks(1);
    chk_bit("max_done", done, 1'b1);
    chk_time("max_0000", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
